// File: rtl/sdram_avl_responder.sv
// sdram_avl_responder
//   Avalon-MM burst responder backed by a word-addressed on-chip memory.
//   Writes land in memory on the accepting clock edge, merged per byte enable.
//   Reads are issued internally one beat per cycle and return after a fixed
//   latency of READ_LAT cycles, in issue order, with no gaps inside a burst.
//   An optional 8-bit LFSR injects pseudo-random waitrequest stalls.
//
// Ports
//   i_clk                clock
//   i_rst                synchronous reset, active-high
//   i_avs_address        burst start word address
//   i_avs_read           read command
//   i_avs_write          write command / write beat
//   i_avs_writedata      write beat data
//   i_avs_byteenable     per-byte write enable
//   i_avs_burstcount     beats in burst (0 behaves as 1), first beat only
//   o_avs_waitrequest    1: command/beat not accepted this cycle
//   o_avs_readdata       read beat data, holds its value between beats
//   o_avs_readdatavalid  read beat valid this cycle
//   o_busy               a burst is active or read beats are still in flight
module sdram_avl_responder #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 12,
  parameter int BURST_W  = 8,
  parameter int READ_LAT = 3,
  parameter int STALL_EN = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_W-1:0]     i_avs_address,
  input  logic                  i_avs_read,
  input  logic                  i_avs_write,
  input  logic [DATA_W-1:0]     i_avs_writedata,
  input  logic [DATA_W/8-1:0]   i_avs_byteenable,
  input  logic [BURST_W-1:0]    i_avs_burstcount,
  output logic                  o_avs_waitrequest,
  output logic [DATA_W-1:0]     o_avs_readdata,
  output logic                  o_avs_readdatavalid,
  output logic                  o_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [BURST_W-1:0]   r_remaining;
  logic [7:0]           r_lfsr;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]    r_pipeData [READ_LAT];
  logic [READ_LAT-1:0]  r_pipeValid;

  logic                 w_stall;
  logic                 w_accept;
  logic                 w_wrBeat;
  logic                 w_rdStart;
  logic                 w_rdIssue;
  logic [ADDR_W-1:0]    w_wrAddr;
  logic [BURST_W-1:0]   w_burst;

  // Reads are held off for the whole of a write burst so that a read can never
  // overtake write beats that are still to come.
  assign w_stall           = (STALL_EN != 0) && (r_lfsr[1:0] == 2'b00);
  assign o_avs_waitrequest = i_rst | (r_state == RD_BURST) |
                             ((r_state == WR_BURST) & i_avs_read) | w_stall;
  assign w_accept          = (i_avs_read | i_avs_write) & ~o_avs_waitrequest;

  // In IDLE a simultaneous read and write is taken as a write; in WR_BURST an
  // accepted transfer is necessarily a write because reads raise waitrequest.
  assign w_wrBeat  = w_accept & i_avs_write;
  assign w_rdStart = w_accept & ~i_avs_write & (r_state == IDLE);
  assign w_rdIssue = (r_state == RD_BURST);
  assign w_wrAddr  = (r_state == IDLE) ? i_avs_address : r_addr;
  assign w_burst   = (i_avs_burstcount == '0) ? BURST_W'(1) : i_avs_burstcount;

  // Memory array: never reset, so contents survive a reset of the control path.
  always_ff @(posedge i_clk) begin
    if (w_wrBeat) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_avs_byteenable[b]) begin
          r_mem[w_wrAddr][b*8 +: 8] <= i_avs_writedata[b*8 +: 8];
        end
      end
    end
  end

  // Burst control: tracks the next word address and the beats still owed.
  // Address increments wrap naturally at 2**ADDR_W.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_lfsr      <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      unique case (r_state)
        IDLE: begin
          if (w_wrBeat) begin
            r_addr      <= i_avs_address + ADDR_W'(1);
            r_remaining <= w_burst - BURST_W'(1);
            if (w_burst != BURST_W'(1)) begin
              r_state <= WR_BURST;
            end
          end else if (w_rdStart) begin
            r_addr      <= i_avs_address;
            r_remaining <= w_burst;
            r_state     <= RD_BURST;
          end
        end
        WR_BURST: begin
          if (w_wrBeat) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - BURST_W'(1);
            if (r_remaining == BURST_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        RD_BURST: begin
          r_addr      <= r_addr + ADDR_W'(1);
          r_remaining <= r_remaining - BURST_W'(1);
          if (r_remaining == BURST_W'(1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read return pipeline: stage 0 captures the memory word on issue, later
  // stages only move data alongside a valid bit, so the last stage keeps the
  // most recently delivered beat while no new beat is presented.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipeValid <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        r_pipeData[i] <= '0;
      end
    end else begin
      r_pipeValid[0] <= w_rdIssue;
      if (w_rdIssue) begin
        r_pipeData[0] <= r_mem[r_addr];
      end
      for (int i = 1; i < READ_LAT; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        if (r_pipeValid[i-1]) begin
          r_pipeData[i] <= r_pipeData[i-1];
        end
      end
    end
  end

  assign o_avs_readdata      = r_pipeData[READ_LAT-1];
  assign o_avs_readdatavalid = r_pipeValid[READ_LAT-1];
  assign o_busy              = (r_state != IDLE) | (|r_pipeValid);

endmodule
